// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray-code helpers and pointer type shared by the queue controller.
package gray_pkg;

    localparam int PTR_W_MAX = 16;

    typedef struct packed {
        logic [PTR_W_MAX-1:0] bin;
        logic [PTR_W_MAX-1:0] gray;
    } gray_ptr_t;

    // Helpers work on zero-extended values, so any width up to PTR_W_MAX is handled.
    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Full when the write pointer equals the read pointer with its two MSBs inverted;
    // at a pointer width of 2 that degenerates to the fully inverted read pointer.
    function automatic logic gray_full(input logic [PTR_W_MAX-1:0] wr_gray,
                                       input logic [PTR_W_MAX-1:0] rd_gray,
                                       input int unsigned           pw);
        logic [PTR_W_MAX-1:0] msb_mask;
        msb_mask = PTR_W_MAX'(3) << (pw - 2);
        return wr_gray == (rd_gray ^ msb_mask);
    endfunction

endpackage

// File: rtl/gray_ptr.sv
// rtl/gray_ptr.sv - Binary pointer with a registered Gray copy, increment and load.
module gray_ptr
    import gray_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    logic [W-1:0] bin_next;

    always_comb begin
        bin_next = bin;
        if (load) begin
            bin_next = load_bin;
        end else if (inc) begin
            bin_next = bin + W'(1);
        end
    end

    // Gray is derived from the next binary value so both registers update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= W'(bin2gray(PTR_W_MAX'(bin_next)));
        end
    end

endmodule

// File: rtl/gray_queue_ctrl.sv
// rtl/gray_queue_ctrl.sv - Single-clock Gray-pointer FIFO controller; GRAY_QUEUE_COUNT_EN adds count.
module gray_queue_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              full,
    output logic              empty
`ifdef GRAY_QUEUE_COUNT_EN
    ,
    output logic [ADDR_W:0]   count
`endif
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin;
    logic          rd_fire;

    // Flags come only from registered Gray pointers.
    assign empty = (wr_ptr_gray == rd_ptr_gray);
    assign full  = gray_full(PTR_W_MAX'(wr_ptr_gray), PTR_W_MAX'(rd_ptr_gray), PW);

    assign wr_ready = !full && !flush;
    assign rd_valid = !empty && !flush;
    assign wr_en    = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    assign wr_addr = wr_bin[ADDR_W-1:0];
    assign rd_addr = rd_bin[ADDR_W-1:0];

    gray_ptr #(.W(PW)) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (wr_en),
        .load     (1'b0),
        .load_bin ('0),
        .bin      (wr_bin),
        .gray     (wr_ptr_gray)
    );

    // Flush empties the queue by snapping the read pointer onto the write pointer.
    gray_ptr #(.W(PW)) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (rd_fire),
        .load     (flush),
        .load_bin (wr_bin),
        .bin      (rd_bin),
        .gray     (rd_ptr_gray)
    );

`ifdef GRAY_QUEUE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_fire})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_gray_queue_ctrl.sv
// tb/tb_gray_queue_ctrl.sv - Directed self-checking bench for gray_queue_ctrl at ADDR_W=2.
module tb_gray_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic       rd_valid;
    logic       rd_ready;
    logic [1:0] rd_addr;
    logic       flush;
    logic [2:0] wr_ptr_gray;
    logic [2:0] rd_ptr_gray;
    logic       full;
    logic       empty;
`ifdef GRAY_QUEUE_COUNT_EN
    logic [2:0] count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gray_queue_ctrl #(.ADDR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .full        (full),
        .empty       (empty)
`ifdef GRAY_QUEUE_COUNT_EN
        ,
        .count       (count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".empty"}, empty, 1'b1);
        chk({tag, ".full"}, full, 1'b0);
        chk({tag, ".rd_valid"}, rd_valid, 1'b0);
        chk({tag, ".wr_ready"}, wr_ready, 1'b1);
        chk({tag, ".wr_en"}, wr_en, 1'b0);
        chk({tag, ".wr_addr"}, wr_addr, 2'd0);
        chk({tag, ".rd_addr"}, rd_addr, 2'd0);
        chk({tag, ".wr_gray"}, wr_ptr_gray, 3'b000);
        chk({tag, ".rd_gray"}, rd_ptr_gray, 3'b000);
`ifdef GRAY_QUEUE_COUNT_EN
        chk({tag, ".count"}, count, 3'd0);
`endif
    endtask

    initial begin
        logic [2:0] wr_gray_exp [4];
        logic [2:0] wb;
        logic [2:0] rb;
        logic [2:0] prev_wg;
        logic [2:0] prev_rg;

        wr_gray_exp[0] = 3'b001;
        wr_gray_exp[1] = 3'b011;
        wr_gray_exp[2] = 3'b010;
        wr_gray_exp[3] = 3'b110;

        // Reset and idle
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        #2;
        check_reset_values("in_reset");
        do_reset();
        tick();
        check_reset_values("idle");

        // Four writes then a blocked fifth
        wr_valid = 1'b1;
        #1;
        chk("first_wr_en", wr_en, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wr_gray_step%0d", k), wr_ptr_gray, wr_gray_exp[k]);
        end
        chk("fill.full", full, 1'b1);
        chk("fill.wr_ready", wr_ready, 1'b0);
        chk("fill.fifth_wr_en", wr_en, 1'b0);
        chk("fill.rd_valid", rd_valid, 1'b1);
        chk("fill.wr_addr_wrap", wr_addr, 2'd0);
`ifdef GRAY_QUEUE_COUNT_EN
        chk("fill.count", count, 3'd4);
`endif
        tick();
        chk("fifth_wr_gray_held", wr_ptr_gray, 3'b110);

        // One read frees a slot
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        #1;
        chk("read1.full", full, 1'b0);
        chk("read1.rd_gray", rd_ptr_gray, 3'b001);
        chk("read1.rd_addr", rd_addr, 2'd1);
        chk("read1.wr_ready", wr_ready, 1'b1);
`ifdef GRAY_QUEUE_COUNT_EN
        chk("read1.count", count, 3'd3);
`endif

        // Streaming write+read at occupancy 1
        do_reset();
        wr_valid = 1'b1;
        tick();
        wb = 3'd1;
        rb = 3'd0;
        rd_ready = 1'b1;
        prev_wg = wr_ptr_gray;
        prev_rg = rd_ptr_gray;
        for (int c = 0; c < 20; c++) begin
            tick();
            wb = wb + 3'd1;
            rb = rb + 3'd1;
            chk($sformatf("stream%0d.wr_addr", c), wr_addr, wb[1:0]);
            chk($sformatf("stream%0d.rd_addr", c), rd_addr, rb[1:0]);
            chk($sformatf("stream%0d.wr_gray", c), wr_ptr_gray, wb ^ (wb >> 1));
            chk($sformatf("stream%0d.wr_onebit", c), $countones(prev_wg ^ wr_ptr_gray), 1);
            chk($sformatf("stream%0d.rd_onebit", c), $countones(prev_rg ^ rd_ptr_gray), 1);
            chk($sformatf("stream%0d.empty", c), empty, 1'b0);
            chk($sformatf("stream%0d.full", c), full, 1'b0);
`ifdef GRAY_QUEUE_COUNT_EN
            chk($sformatf("stream%0d.count", c), count, 3'd1);
`endif
            prev_wg = wr_ptr_gray;
            prev_rg = rd_ptr_gray;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Flush with both sides requesting
        do_reset();
        wr_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("preflush.wr_gray", wr_ptr_gray, 3'b010);
        flush    = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk("flush.wr_en", wr_en, 1'b0);
        chk("flush.rd_valid", rd_valid, 1'b0);
        chk("flush.wr_ready", wr_ready, 1'b0);
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        chk("postflush.empty", empty, 1'b1);
        chk("postflush.wr_gray", wr_ptr_gray, 3'b010);
        chk("postflush.rd_gray", rd_ptr_gray, 3'b010);
`ifdef GRAY_QUEUE_COUNT_EN
        chk("postflush.count", count, 3'd0);
`endif

        // Asynchronous reset with two words queued
        do_reset();
        wr_valid = 1'b1;
        tick();
        tick();
        wr_valid = 1'b0;
        #1;
        chk("midrst.pre_empty", empty, 1'b0);
        chk("midrst.pre_wr_addr", wr_addr, 2'd2);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_queue_ctrl.md
# gray_queue_ctrl

Single-clock FIFO controller that owns the read and write pointers for a power-of-two queue and keeps them in Gray code. It sits between a producer and a consumer with valid/ready handshakes. It drives the write/read addresses of an external storage array (LUT RAM or iCE40 EBR). Its Gray pointers are exported unchanged so a later dual-clock variant can synchronise them across domains.

## Interface
- `ADDR_W`, default 4: storage address width; depth = 2**ADDR_W, pointer width PW = ADDR_W+1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `wr_valid` in 1: producer has a word.
- `wr_ready` out 1: controller accepts a word this cycle.
- `wr_en` out 1: storage write strobe, = `wr_valid & wr_ready`.
- `wr_addr` out ADDR_W: storage write address (tail).
- `rd_valid` out 1: head word available.
- `rd_ready` in 1: consumer takes the head word.
- `rd_addr` out ADDR_W: storage read address (head).
- `flush` in 1: discard all queued words.
- `wr_ptr_gray` out PW: registered Gray write pointer.
- `rd_ptr_gray` out PW: registered Gray read pointer.
- `full` out 1: queue holds 2**ADDR_W words.
- `empty` out 1: queue holds no words.
- `count` out PW: occupancy; present only with `GRAY_QUEUE_COUNT_EN`.

## Operation
- State per side: PW-bit binary counter plus registered Gray copy, gray = bin ^ (bin >> 1).
- Write fire = `wr_valid & wr_ready`; `wr_ready` = `!full & !flush`.
- Read fire = `rd_valid & rd_ready`; `rd_valid` = `!empty & !flush`.
- On a write fire, wr_bin increments by one, modulo 2**PW.
- On a read fire, rd_bin increments by one, modulo 2**PW.
- `wr_addr` = wr_bin[ADDR_W-1:0] and `rd_addr` = rd_bin[ADDR_W-1:0]; both wrap to 0 after 2**ADDR_W-1.
- `empty` = (wr_ptr_gray == rd_ptr_gray).
- `full` = (wr_ptr_gray == {~rd_ptr_gray[PW-1:PW-2], rd_ptr_gray[PW-3:0]}).
  - For ADDR_W=1, `full` compares against the fully inverted rd_ptr_gray.
- Flags are decoded only from registered pointers; no input-to-flag combinational path.
- Simultaneous write and read fire: both pointers advance and occupancy is unchanged. This is legal when full (`wr_ready`=0 blocks it) only while not full, and when empty only for the write side.
- `flush` (synchronous): rd_bin <= wr_bin and rd_ptr_gray <= wr_ptr_gray. No fires occur that cycle; the queue is empty on the next cycle.
- Reset or reset mid-operation: all pointers go to 0 asynchronously and in-flight words are lost.
  - Reset values: `empty`=1, `full`=0, `rd_valid`=0, `wr_en`=0, `wr_ready`=1 (for `flush`=0), `wr_addr`=`rd_addr`=0, Gray pointers 0, `count`=0.

## Timing
- Write-to-visible latency is 1 cycle: a write fire at edge N makes `rd_valid` high after edge N.
- Read fire updates `rd_addr` after the same edge.
  - With registered-read storage, the consumer must register `rd_addr` externally; the controller adds no read pipeline.
- `full` deasserts the cycle after the read fire that frees a slot.
- Each pointer's Gray output changes in exactly one bit per increment, including the wrap from 2**PW-1 to 0.

## Configuration
- `GRAY_QUEUE_COUNT_EN` defined: `count` port exists and is registered.
  - Updates: +1 on write-only, −1 on read-only, unchanged on both or neither.
  - Set to 0 on flush or reset.
  - Always equals (wr_bin − rd_bin) mod 2**PW.
- Not defined: no `count` port and no counter logic; all other behaviour is identical.

## Structure
- Package `gray_pkg` holds:
  - functions `bin2gray` / `gray2bin`, parameterised by width;
  - typedef of the pointer struct {bin, gray};
  - the full-compare helper.
- Sub-module `gray_ptr`:
  - inputs: `clk`, `rst_n`, `inc`, `load`, `load_bin`;
  - outputs: `bin`, `gray`;
  - instantiated twice (write side, read side). Only the read side uses `load`, for flush.

## Test plan
All scenarios use ADDR_W=2 (depth 4, PW=3).
- Reset, then idle → `empty`=1, `full`=0, `rd_valid`=0, `wr_ready`=1, both Gray pointers 3'b000.
- 4 writes, no reads:
  - → wr_ptr_gray steps 001, 011, 010, 110;
  - → `full`=1 after the 4th write, `wr_ready`=0;
  - → a 5th `wr_valid` produces no `wr_en`.
- Fill to 4, then one read → `full`=0 next cycle; rd_ptr_gray=001, `rd_addr`=1.
- Continuous write+read for 20 cycles → occupancy constant at 1; `wr_addr` and `rd_addr` wrap 3→0; every Gray pointer transition differs by one bit.
- 3 writes, then `flush` with `wr_valid`=`rd_ready`=1 → no fire that cycle; next cycle `empty`=1, rd_ptr_gray=wr_ptr_gray=010, `count`=0 (when enabled).
- `rst_n` pulsed low mid-stream with 2 words queued → outputs return to reset values immediately, without waiting for a clock edge.
